// File: rtl/counter_pkg.sv
// Shared types and defaults for the mod-N up/down counter family.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   count_dir_e    - count direction (DOWN=0, UP=1), matches the mode pin
//   count_policy_e - range-end policy (SATURATE=0, WRAP=1), matches wrap_en
//   CNT_WIDTH      - default counter width
//   CNT_MODULUS    - default modulus
//   modulus_ok()   - legality check for a WIDTH/MODULUS pair
package counter_pkg;

  localparam int CNT_WIDTH   = 4;
  localparam int CNT_MODULUS = 12;

  typedef enum logic {
    DOWN = 1'b0,
    UP   = 1'b1
  } count_dir_e;

  typedef enum logic {
    SATURATE = 1'b0,
    WRAP     = 1'b1
  } count_policy_e;

  // A modulus is usable when it has at least two states and every state
  // is representable in WIDTH bits.
  function automatic bit modulus_ok(input int width, input int modulus);
    return (modulus >= 2) && (modulus <= (1 << width));
  endfunction

endpackage

// File: rtl/mod_n_next_val.sv
// Next-count generator: given the current count, direction and end policy,
// produces the value the counter would take on an enabled edge.
// Latency: purely combinational. Backpressure: none.
//
// Ports:
//   i_dout    [WIDTH-1:0]  current count (assumed 0..MODULUS-1)
//   i_mode                 1 = up, 0 = down
//   i_wrap_en              1 = wrap at range ends, 0 = saturate
//   o_next    [WIDTH-1:0]  count after one enabled step
//   o_at_end               current count sits at the end being counted toward
module mod_n_next_val
  import counter_pkg::*;
#(
  parameter int WIDTH   = CNT_WIDTH,
  parameter int MODULUS = CNT_MODULUS
) (
  input  logic [WIDTH-1:0] i_dout,
  input  logic             i_mode,
  input  logic             i_wrap_en,
  output logic [WIDTH-1:0] o_next,
  output logic             o_at_end
);

  localparam logic [WIDTH:0]   L_MOD = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] L_MAX = WIDTH'(MODULUS - 1);

  count_dir_e    w_dir;
  count_policy_e w_policy;
  logic [WIDTH:0] w_ext;
  logic [WIDTH:0] w_inc;
  logic [WIDTH:0] w_dec;
  logic           w_up_end;
  logic           w_down_end;

  assign w_dir    = count_dir_e'(i_mode);
  assign w_policy = count_policy_e'(i_wrap_en);

  // One extra bit keeps +1 at 2**WIDTH-1 and -1 at 0 from aliasing.
  assign w_ext = {1'b0, i_dout};
  assign w_inc = w_ext + (WIDTH+1)'(1);
  assign w_dec = w_ext - (WIDTH+1)'(1);

  // Up end: the increment would reach MODULUS. Down end: the decrement
  // borrows into the extra bit, i.e. the count was 0.
  assign w_up_end   = (w_inc >= L_MOD);
  assign w_down_end = w_dec[WIDTH];

  always_comb begin
    o_next   = i_dout;
    o_at_end = 1'b0;
    if (w_dir == UP) begin
      o_at_end = w_up_end;
      if (w_up_end) begin
        o_next = (w_policy == WRAP) ? '0 : L_MAX;
      end else begin
        o_next = w_inc[WIDTH-1:0];
      end
    end else begin
      o_at_end = w_down_end;
      if (w_down_end) begin
        o_next = (w_policy == WRAP) ? L_MAX : '0;
      end else begin
        o_next = w_dec[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/mod_n_updown_counter.sv
// Loadable mod-N up/down counter with wrap/saturate policy and registered
// terminal-count and load-error flags.
// Latency: 1 cycle, all outputs registered. Backpressure: none (en gates counting).
//
// Ports:
//   clk                   rising-edge clock
//   rstn                  async active-low reset
//   load                  synchronous load of data_in (beats en)
//   en                    count enable
//   mode                  1 = up, 0 = down
//   wrap_en               1 = wrap at range ends, 0 = saturate
//   data_in  [WIDTH-1:0]  load value
//   dout     [WIDTH-1:0]  current count, always in 0..MODULUS-1
//   tc                    high after any enabled edge taken at a range end
//   load_err              high for one cycle after an out-of-range load
module mod_n_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = CNT_WIDTH,
  parameter int MODULUS = CNT_MODULUS
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic             en,
  input  logic             mode,
  input  logic             wrap_en,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] dout,
  output logic             tc,
  output logic             load_err
);

  if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
    $error("mod_n_updown_counter: MODULUS must be in 2..2**WIDTH");
  end

  localparam logic [WIDTH:0] L_MOD = (WIDTH+1)'(MODULUS);

  logic [WIDTH-1:0] r_dout;
  logic             r_tc;
  logic             r_load_err;

  logic [WIDTH-1:0] w_next;
  logic             w_at_end;
  logic             w_load_ok;

  mod_n_next_val #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next_val (
    .i_dout    (r_dout),
    .i_mode    (mode),
    .i_wrap_en (wrap_en),
    .o_next    (w_next),
    .o_at_end  (w_at_end)
  );

  // Compared in WIDTH+1 bits so MODULUS == 2**WIDTH accepts every value.
  assign w_load_ok = ({1'b0, data_in} < L_MOD);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_dout     <= '0;
      r_tc       <= 1'b0;
      r_load_err <= 1'b0;
    end else if (load) begin
      r_tc <= 1'b0;
      if (w_load_ok) begin
        r_dout     <= data_in;
        r_load_err <= 1'b0;
      end else begin
        // Rejected load leaves the count untouched.
        r_load_err <= 1'b1;
      end
    end else if (en) begin
      // tc follows at_end every enabled edge, so a saturated count keeps it high.
      r_dout     <= w_next;
      r_tc       <= w_at_end;
      r_load_err <= 1'b0;
    end else begin
      r_tc       <= 1'b0;
      r_load_err <= 1'b0;
    end
  end

  assign dout     = r_dout;
  assign tc       = r_tc;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Directed bench for mod_n_updown_counter at WIDTH=4, MODULUS=12.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_mod_n_updown_counter;

  localparam int WIDTH   = 4;
  localparam int MODULUS = 12;

  logic             clk;
  logic             rstn;
  logic             load;
  logic             en;
  logic             mode;
  logic             wrap_en;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] dout;
  logic             tc;
  logic             load_err;

  int total;
  int bad;

  mod_n_updown_counter #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .load     (load),
    .en       (en),
    .mode     (mode),
    .wrap_en  (wrap_en),
    .data_in  (data_in),
    .dout     (dout),
    .tc       (tc),
    .load_err (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int val);
    load    = 1'b1;
    en      = 1'b0;
    data_in = WIDTH'(val);
    step();
    load    = 1'b0;
  endtask

  task automatic test_reset();
    rstn    = 1'b0;
    load    = 1'b0;
    en      = 1'b1;
    mode    = 1'b1;
    wrap_en = 1'b1;
    data_in = '0;
    #2;
    total++;
    if (dout !== 4'd0 || tc !== 1'b0 || load_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_initial: dout=%0d tc=%0b err=%0b required 0/0/0", dout, tc, load_err);
    end
    step();
    step();
    total++;
    if (dout !== 4'd0 || tc !== 1'b0 || load_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_held: dout=%0d tc=%0b err=%0b required 0/0/0", dout, tc, load_err);
    end
    en   = 1'b0;
    rstn = 1'b1;
  endtask

  task automatic test_wrap_up();
    int exp_d;
    en      = 1'b1;
    mode    = 1'b1;
    wrap_en = 1'b1;
    for (int k = 0; k < 14; k++) begin
      step();
      exp_d = (k + 1) % 12;
      total++;
      if (dout !== WIDTH'(exp_d) || tc !== (exp_d == 0)) begin
        bad++;
        $display("FAIL wrap_up[%0d]: dout=%0d tc=%0b required %0d/%0b", k, dout, tc, exp_d, exp_d == 0);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_wrap_down();
    int exp_d[7] = '{4, 3, 2, 1, 0, 11, 10};
    bit exp_t[7] = '{0, 0, 0, 0, 0, 1, 0};
    do_load(5);
    total++;
    if (dout !== 4'd5 || tc !== 1'b0 || load_err !== 1'b0) begin
      bad++;
      $display("FAIL load5: dout=%0d tc=%0b err=%0b required 5/0/0", dout, tc, load_err);
    end
    en      = 1'b1;
    mode    = 1'b0;
    wrap_en = 1'b1;
    for (int k = 0; k < 7; k++) begin
      step();
      total++;
      if (dout !== WIDTH'(exp_d[k]) || tc !== exp_t[k]) begin
        bad++;
        $display("FAIL wrap_down[%0d]: dout=%0d tc=%0b required %0d/%0b", k, dout, tc, exp_d[k], exp_t[k]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_saturate();
    bit exp_t[4] = '{0, 1, 1, 1};
    wrap_en = 1'b0;
    do_load(10);
    en   = 1'b1;
    mode = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if (dout !== 4'd11 || tc !== exp_t[k]) begin
        bad++;
        $display("FAIL sat_up[%0d]: dout=%0d tc=%0b required 11/%0b", k, dout, tc, exp_t[k]);
      end
    end
    do_load(1);
    en   = 1'b1;
    mode = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (dout !== 4'd0 || tc !== (k != 0)) begin
        bad++;
        $display("FAIL sat_down[%0d]: dout=%0d tc=%0b required 0/%0b", k, dout, tc, k != 0);
      end
    end
    // Mode flip at the bottom: next edge counts up again with tc low.
    mode = 1'b1;
    step();
    total++;
    if (dout !== 4'd1 || tc !== 1'b0) begin
      bad++;
      $display("FAIL sat_turnaround: dout=%0d tc=%0b required 1/0", dout, tc);
    end
    en      = 1'b0;
    wrap_en = 1'b1;
  endtask

  task automatic test_load_err();
    do_load(7);
    do_load(13);
    total++;
    if (dout !== 4'd7 || load_err !== 1'b1 || tc !== 1'b0) begin
      bad++;
      $display("FAIL load13: dout=%0d err=%0b tc=%0b required 7/1/0", dout, load_err, tc);
    end
    do_load(3);
    total++;
    if (dout !== 4'd3 || load_err !== 1'b0) begin
      bad++;
      $display("FAIL load3: dout=%0d err=%0b required 3/0", dout, load_err);
    end
    // Exactly MODULUS is the first illegal value; the flag lasts one cycle.
    do_load(12);
    total++;
    if (dout !== 4'd3 || load_err !== 1'b1) begin
      bad++;
      $display("FAIL load12: dout=%0d err=%0b required 3/1", dout, load_err);
    end
    step();
    total++;
    if (dout !== 4'd3 || load_err !== 1'b0) begin
      bad++;
      $display("FAIL err_clear: dout=%0d err=%0b required 3/0", dout, load_err);
    end
    do_load(11);
    total++;
    if (dout !== 4'd11 || load_err !== 1'b0) begin
      bad++;
      $display("FAIL load11: dout=%0d err=%0b required 11/0", dout, load_err);
    end
  endtask

  task automatic test_load_priority();
    do_load(9);
    load    = 1'b1;
    en      = 1'b1;
    mode    = 1'b1;
    data_in = 4'd2;
    step();
    load = 1'b0;
    en   = 1'b0;
    total++;
    if (dout !== 4'd2 || tc !== 1'b0) begin
      bad++;
      $display("FAIL load_beats_en: dout=%0d tc=%0b required 2/0", dout, tc);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (dout !== 4'd2 || tc !== 1'b0) begin
        bad++;
        $display("FAIL hold[%0d]: dout=%0d tc=%0b required 2/0", k, dout, tc);
      end
    end
  endtask

  task automatic test_async_reset();
    do_load(8);
    do_load(14);
    total++;
    if (dout !== 4'd8 || load_err !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset: dout=%0d err=%0b required 8/1", dout, load_err);
    end
    en      = 1'b1;
    mode    = 1'b1;
    wrap_en = 1'b1;
    #2;
    rstn = 1'b0;
    #1;
    total++;
    if (dout !== 4'd0 || tc !== 1'b0 || load_err !== 1'b0) begin
      bad++;
      $display("FAIL async_clear: dout=%0d tc=%0b err=%0b required 0/0/0", dout, tc, load_err);
    end
    step();
    total++;
    if (dout !== 4'd0) begin
      bad++;
      $display("FAIL reset_hold_en: dout=%0d required 0", dout);
    end
    rstn = 1'b1;
    step();
    total++;
    if (dout !== 4'd1 || tc !== 1'b0) begin
      bad++;
      $display("FAIL restart: dout=%0d tc=%0b required 1/0", dout, tc);
    end
    en = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_load_err();
    test_load_priority();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mod_n_updown_counter.md
Name: mod_n_updown_counter

Overview:
- Parametrised successor to the team's fixed mod-12 loadable up/down counter.
- Supports a programmable modulus and width, a count enable, and a wrap-or-saturate policy.
- Provides registered terminal-count and load-error flags.
- Standalone counter leaf, instantiated under the counter testbench top and reused by timer/divider blocks.

Parameters:
- WIDTH, 4, bit width of data_in and dout; must satisfy 2**WIDTH >= MODULUS.
- MODULUS, 12, count range 0..MODULUS-1; legal range 2..2**WIDTH.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rstn  input  1  asynchronous, active-low reset.
- load  input  1  synchronous load of data_in.
- en  input  1  count enable.
- mode  input  1  1 = count up, 0 = count down.
- wrap_en  input  1  1 = wrap at the range ends, 0 = saturate at the range ends.
- data_in  input  WIDTH  load value.
- dout  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered.
- load_err  output  1  out-of-range load flag, registered.

Behaviour:
- Reset (rstn low, async): dout=0, tc=0, load_err=0. Outputs hold these values while rstn is low.
- First update after reset deassertion happens on the first rising clk edge with rstn high.
- Per-edge priority: load > en > hold.
- load=1, data_in < MODULUS: dout<=data_in, load_err<=0, tc<=0.
- load=1, data_in >= MODULUS: dout unchanged, load_err<=1 for that cycle, tc<=0.
- load=0, en=1, mode=1:
  - If dout==MODULUS-1 and wrap_en=1: dout<=0, tc<=1.
  - If dout==MODULUS-1 and wrap_en=0: dout holds at MODULUS-1, tc<=1.
  - Otherwise: dout<=dout+1, tc<=0.
- load=0, en=1, mode=0:
  - If dout==0 and wrap_en=1: dout<=MODULUS-1, tc<=1.
  - If dout==0 and wrap_en=0: dout holds at 0, tc<=1.
  - Otherwise: dout<=dout-1, tc<=0.
- load=0, en=0: dout holds, tc<=0.
- load_err<=0 on every edge without an illegal load.
- Latency: dout, tc and load_err reflect the inputs sampled at edge N, visible after edge N. tc asserts on the same edge the wrap or saturation occurs.
- Saturation: while en stays high and the count is pinned at an end, tc stays high every cycle (sticky-level behaviour in saturate mode).
- Mode change between cycles takes effect on the next edge; there is no pipeline state.
- Arithmetic uses WIDTH+1-bit intermediates so no intermediate overflow occurs; dout never leaves 0..MODULUS-1.
- MODULUS == 2**WIDTH is legal. In that case load_err can never assert.
- Reset asserted mid-count: immediate clear; the count does not resume from its previous value.
- Elaboration assertions: MODULUS >= 2 and MODULUS <= 2**WIDTH.

Decomposition:
- Package counter_pkg:
  - count_dir_e enum (DOWN=0, UP=1).
  - count_policy_e enum (SATURATE=0, WRAP=1).
  - Default constants CNT_WIDTH=4, CNT_MODULUS=12.
- One combinational sub-module, mod_n_next_val.
  - Inputs: dout, mode, wrap_en.
  - Outputs: next value and an at_end flag.
  - Reused by the scoreboard reference model.
- The top counter holds the registers and the load/enable priority.

Test Plan (WIDTH=4, MODULUS=12):
- Reset, then en=1, mode=1, wrap_en=1 for 14 cycles -> dout 1..11, 0, 1, 2; tc high only on the edge producing 0.
- Load 5, then mode=0, wrap_en=1, en=1 for 7 cycles -> dout 4, 3, 2, 1, 0, 11, 10; tc high on the edge producing 11.
- wrap_en=0, load 10, mode=1, en=1 for 4 cycles -> dout 11, 11, 11, 11; tc=0, 1, 1, 1 (1 on every cycle at 11).
- Load 13 while dout=7 -> dout stays 7, load_err=1 for one cycle; then load 3 -> dout=3, load_err=0.
- Simultaneous load=1 (data 2) and en=1 while dout=9 -> dout=2, tc=0; then en=0 for 3 cycles -> dout holds 2.
- Assert rstn low asynchronously mid-cycle at dout=8 -> dout=0 before the next edge; release -> counting restarts from 0, giving 1 on the first enabled edge.
